mem_stage: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline, sitting between the EX/MEM register and the write-back stage. Each cycle it:
- issues loads and stores to the data-memory port, using a variable-latency req/ready handshake;
- aligns, masks and sign- or zero-extends load data;
- registers the MEM/WB pipeline outputs consumed by write-back.

While a memory access is outstanding it stalls the upstream pipeline.

---
 rtl/rv32_pkg.sv | 15 +
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings and the MEM stage FSM states.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE,
        MEM_BUSY
    } mem_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/halfword lane from the read word and extends it.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Halfword lane ignores addr[0], so misaligned halfwords fall back to the aligned lane.
    assign byteLane = rdata[{addr, 3'b000} +: 8];
    assign halfLane = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byteLane[7]}}, byteLane};
            F3_BU:   data = {24'h000000, byteLane};
            F3_H:    data = {{16{halfLane[15]}}, halfLane};
            F3_HU:   data = {16'h0000, halfLane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory handshake with timeout, load alignment and the MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN suppresses misaligned H/W accesses and adds mem_misalign.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst_,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu,
    input  logic [31:0] ex_mem_store_data,
    input  logic [4:0]  ex_mem_rd_addr,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_to_reg,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic        mem_bus_err,
    output logic [31:0] mem_wb_alu,
    output logic [31:0] mem_wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        mem_misalign
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    logic          misalign, pending, timeoutNow;
    logic [3:0]    storeBe;
    logic [31:0]   storeWdata, loadData;

    logic [31:0]   wbAlu_q, wbAlu_d, wbData_q, wbData_d;
    logic [4:0]    wbRd_q, wbRd_d;
    logic          wbRegWrite_q, wbRegWrite_d, wbMemToReg_q, wbMemToReg_d;
    logic          busErr_q, busErr_d;

`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
    assign misalign = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write) &
                      (((ex_mem_funct3 == F3_H) || (ex_mem_funct3 == F3_HU)) ? ex_mem_alu[0] :
                       ((ex_mem_funct3 == F3_B) || (ex_mem_funct3 == F3_BU)) ? 1'b0 :
                       (ex_mem_alu[1:0] != 2'b00));
    assign mem_misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign pending = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write) & ~misalign;

    // Counter holds the number of wait cycles elapsed since the first request cycle.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        timeoutNow = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                waitCnt_d = '0;
                if (pending && !dmem_ready) begin
                    state_d   = MEM_BUSY;
                    waitCnt_d = CW'(1);
                end
            end
            MEM_BUSY: begin
                if (!pending || dmem_ready) begin
                    state_d   = MEM_IDLE;
                    waitCnt_d = '0;
                end else if (waitCnt_q == CW'(TIMEOUT_CYCLES)) begin
                    timeoutNow = 1'b1;
                    state_d    = MEM_IDLE;
                    waitCnt_d  = '0;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q   <= MEM_IDLE;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Gating with reset withdraws the request in the same cycle reset arrives.
    assign dmem_req  = pending & ~rst_;
    assign mem_stall = pending & ~dmem_ready & ~timeoutNow & ~rst_;

    always_comb begin
        storeBe    = 4'b1111;
        storeWdata = ex_mem_store_data;
        if (ex_mem_mem_write) begin
            case (ex_mem_funct3)
                F3_B: begin
                    storeBe    = 4'b0001 << ex_mem_alu[1:0];
                    storeWdata = {4{ex_mem_store_data[7:0]}};
                end
                F3_H: begin
                    storeBe    = 4'b0011 << {ex_mem_alu[1], 1'b0};
                    storeWdata = {2{ex_mem_store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign dmem_we    = dmem_req & ex_mem_mem_write;
    assign dmem_addr  = dmem_req ? {ex_mem_alu[31:2], 2'b00} : 32'h0;
    assign dmem_be    = dmem_req ? storeBe : 4'b0000;
    assign dmem_wdata = dmem_we ? storeWdata : 32'h0;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (ex_mem_alu[1:0]),
        .funct3 (ex_mem_funct3),
        .data   (loadData)
    );

    // Bubbles clear only the write-back controls; data fields hold their previous values.
    always_comb begin
        wbAlu_d      = wbAlu_q;
        wbData_d     = wbData_q;
        wbRd_d       = wbRd_q;
        wbRegWrite_d = 1'b0;
        wbMemToReg_d = 1'b0;
        busErr_d     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
`endif
        if (ex_mem_valid && !mem_stall) begin
            wbAlu_d = ex_mem_alu;
            wbRd_d  = ex_mem_rd_addr;
            if (timeoutNow) begin
                wbData_d = 32'h0;
                busErr_d = 1'b1;
            end else if (misalign) begin
`ifdef MEM_MISALIGN_TRAP_EN
                misalign_d = 1'b1;
`endif
            end else begin
                wbRegWrite_d = ex_mem_reg_write;
                wbMemToReg_d = ex_mem_mem_to_reg;
                wbData_d     = ex_mem_mem_read ? loadData : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            wbAlu_q      <= '0;
            wbData_q     <= '0;
            wbRd_q       <= '0;
            wbRegWrite_q <= 1'b0;
            wbMemToReg_q <= 1'b0;
            busErr_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            wbAlu_q      <= wbAlu_d;
            wbData_q     <= wbData_d;
            wbRd_q       <= wbRd_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbMemToReg_q <= wbMemToReg_d;
            busErr_q     <= busErr_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign mem_wb_alu    = wbAlu_q;
    assign mem_wb_data   = wbData_q;
    assign wb_rd_addr    = wbRd_q;
    assign wb_reg_write  = wbRegWrite_q;
    assign wb_mem_to_reg = wbMemToReg_q;
    assign mem_bus_err   = busErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: zero-wait vector table plus wait, timeout and reset sequences.
module tb_mem_stage;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        exValid = 1'b0;
    logic [31:0] exAlu = '0;
    logic [31:0] exStoreData = '0;
    logic [4:0]  exRd = '0;
    logic        exRegWrite = 1'b0;
    logic        exMemToReg = 1'b0;
    logic        exMemRead = 1'b0;
    logic        exMemWrite = 1'b0;
    logic [2:0]  exFunct3 = '0;
    logic [31:0] dmemRdata = '0;
    logic        dmemReady = 1'b0;

    logic        dmemReq, dmemWe, memStall, memBusErr, wbRegWrite, wbMemToReg;
    logic [31:0] dmemAddr, dmemWdata, memWbAlu, memWbData;
    logic [3:0]  dmemBe;
    logic [4:0]  wbRdAddr;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst_              (rst_),
        .ex_mem_valid      (exValid),
        .ex_mem_alu        (exAlu),
        .ex_mem_store_data (exStoreData),
        .ex_mem_rd_addr    (exRd),
        .ex_mem_reg_write  (exRegWrite),
        .ex_mem_mem_to_reg (exMemToReg),
        .ex_mem_mem_read   (exMemRead),
        .ex_mem_mem_write  (exMemWrite),
        .ex_mem_funct3     (exFunct3),
        .dmem_req          (dmemReq),
        .dmem_we           (dmemWe),
        .dmem_addr         (dmemAddr),
        .dmem_be           (dmemBe),
        .dmem_wdata        (dmemWdata),
        .dmem_rdata        (dmemRdata),
        .dmem_ready        (dmemReady),
        .mem_stall         (memStall),
        .mem_bus_err       (memBusErr),
        .mem_wb_alu        (memWbAlu),
        .mem_wb_data       (memWbData),
        .wb_rd_addr        (wbRdAddr),
        .wb_reg_write      (wbRegWrite),
        .wb_mem_to_reg     (wbMemToReg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        isRead;
        logic        isWrite;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        expReq;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expWe;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[11];

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] sdata, input logic [4:0] rdAddr,
                                 input logic rw, input logic m2r, input logic ready,
                                 input logic [31:0] rdata);
        exValid     = valid;
        exMemRead   = rd;
        exMemWrite  = wr;
        exFunct3    = f3;
        exAlu       = alu;
        exStoreData = sdata;
        exRd        = rdAddr;
        exRegWrite  = rw;
        exMemToReg  = m2r;
        dmemReady   = ready;
        dmemRdata   = rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"lw_zero_wait",  1, 0, F3W,  32'h100, 32'h0,        32'hDEADBEEF, 5'd7, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'hDEADBEEF};
        vecs[1]  = '{"lb",            1, 0, F3B,  32'h103, 32'h0,        32'h80FF0000, 5'd1, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'hFFFFFF80};
        vecs[2]  = '{"lbu",           1, 0, F3BU, 32'h103, 32'h0,        32'h80FF0000, 5'd2, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'h00000080};
        vecs[3]  = '{"lh",            1, 0, F3H,  32'h102, 32'h0,        32'h80FF0000, 5'd3, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'hFFFF80FF};
        vecs[4]  = '{"lhu",           1, 0, F3HU, 32'h100, 32'h0,        32'h80FFF234, 5'd4, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'h0000F234};
        vecs[5]  = '{"lh_misaligned", 1, 0, F3H,  32'h101, 32'h0,        32'h80FF7F01, 5'd5, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'h00007F01};
        vecs[6]  = '{"lw_misaligned", 1, 0, F3W,  32'h103, 32'h0,        32'h01020304, 5'd6, 1, 1, 1, 32'h100, 4'hF, 32'h0,        0, 32'h01020304};
        vecs[7]  = '{"sh",            0, 1, F3H,  32'h022, 32'h1234ABCD, 32'h0,        5'd0, 0, 0, 1, 32'h020, 4'hC, 32'hABCDABCD, 1, 32'h0};
        vecs[8]  = '{"sb",            0, 1, F3B,  32'h041, 32'hFFFFFFA5, 32'h0,        5'd0, 0, 0, 1, 32'h040, 4'h2, 32'hA5A5A5A5, 1, 32'h0};
        vecs[9]  = '{"sw",            0, 1, F3W,  32'h080, 32'hCAFEF00D, 32'h0,        5'd0, 0, 0, 1, 32'h080, 4'hF, 32'hCAFEF00D, 1, 32'h0};
        vecs[10] = '{"alu_op",        0, 0, F3W,  32'h055, 32'h0,        32'h0,        5'd3, 1, 0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};

        #2 rst_ = 1'b1;
        #1;
        checkOutput("reset_req", dmemReq, 1'b0);
        checkOutput("reset_stall", memStall, 1'b0);
        checkOutput("reset_wb_alu", memWbAlu, 32'h0);
        checkOutput("reset_wb_reg_write", wbRegWrite, 1'b0);
        checkOutput("reset_bus_err", memBusErr, 1'b0);
        @(negedge clk);
        rst_ = 1'b0;

        // Zero-wait vectors: check the request side before the edge, MEM/WB after it.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(1, vecs[i].isRead, vecs[i].isWrite, vecs[i].f3, vecs[i].alu, vecs[i].sdata,
                          vecs[i].rd, vecs[i].rw, vecs[i].m2r, 1, vecs[i].rdata);
            #1;
            checkOutput({vecs[i].name, "_req"}, dmemReq, vecs[i].expReq);
            checkOutput({vecs[i].name, "_stall"}, memStall, 1'b0);
            if (vecs[i].expReq) begin
                checkOutput({vecs[i].name, "_addr"}, dmemAddr, vecs[i].expAddr);
                checkOutput({vecs[i].name, "_be"}, dmemBe, vecs[i].expBe);
                checkOutput({vecs[i].name, "_we"}, dmemWe, vecs[i].expWe);
            end
            if (vecs[i].isWrite)
                checkOutput({vecs[i].name, "_wdata"}, dmemWdata, vecs[i].expWdata);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_wb_reg_write"}, wbRegWrite, vecs[i].rw);
            checkOutput({vecs[i].name, "_wb_mem_to_reg"}, wbMemToReg, vecs[i].m2r);
            checkOutput({vecs[i].name, "_wb_rd"}, wbRdAddr, vecs[i].rd);
            checkOutput({vecs[i].name, "_wb_alu"}, memWbAlu, vecs[i].alu);
            if (vecs[i].isRead)
                checkOutput({vecs[i].name, "_wb_data"}, memWbData, vecs[i].expData);
        end

        // Three-wait load: three stalled cycles with bubbles, then completion.
        @(negedge clk);
        applyStimulus(1, 1, 0, F3W, 32'h200, 0, 5'd9, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("wait3_stall", memStall, 1'b1);
            checkOutput("wait3_req", dmemReq, 1'b1);
            checkOutput("wait3_addr", dmemAddr, 32'h200);
            @(posedge clk);
            #1;
            checkOutput("wait3_bubble", wbRegWrite, 1'b0);
            @(negedge clk);
        end
        dmemReady = 1'b1;
        dmemRdata = 32'h11223344;
        #1;
        checkOutput("wait3_stall_release", memStall, 1'b0);
        checkOutput("wait3_addr_final", dmemAddr, 32'h200);
        @(posedge clk);
        #1;
        checkOutput("wait3_wb_reg_write", wbRegWrite, 1'b1);
        checkOutput("wait3_wb_data", memWbData, 32'h11223344);
        checkOutput("wait3_wb_rd", wbRdAddr, 5'd9);

        // Timeout with ready never asserted.
        @(negedge clk);
        applyStimulus(1, 1, 0, F3W, 32'h300, 0, 5'd4, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("timeout_stall", memStall, 1'b1);
            @(posedge clk);
            #1;
            checkOutput("timeout_err_early", memBusErr, 1'b0);
            checkOutput("timeout_bubble", wbRegWrite, 1'b0);
            @(negedge clk);
        end
        #1;
        checkOutput("timeout_stall_release", memStall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("timeout_err_pulse", memBusErr, 1'b1);
        checkOutput("timeout_wb_reg_write", wbRegWrite, 1'b0);
        checkOutput("timeout_wb_data", memWbData, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, F3W, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("timeout_err_one_cycle", memBusErr, 1'b0);
        @(negedge clk);
        applyStimulus(1, 1, 0, F3W, 32'h400, 0, 5'd8, 1, 1, 1, 32'h0BADF00D);
        #1;
        checkOutput("after_timeout_idle_stall", memStall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("after_timeout_data", memWbData, 32'h0BADF00D);

        // Ready arriving in the timeout cycle wins.
        @(negedge clk);
        applyStimulus(1, 1, 0, F3W, 32'h500, 0, 5'd11, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        dmemReady = 1'b1;
        dmemRdata = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        checkOutput("ready_vs_timeout_err", memBusErr, 1'b0);
        checkOutput("ready_vs_timeout_wb", wbRegWrite, 1'b1);
        checkOutput("ready_vs_timeout_data", memWbData, 32'hA5A55A5A);

        // Reset in the middle of a wait.
        @(negedge clk);
        applyStimulus(1, 1, 0, F3W, 32'h600, 0, 5'd12, 1, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        checkOutput("rst_busy_req", dmemReq, 1'b0);
        checkOutput("rst_busy_stall", memStall, 1'b0);
        checkOutput("rst_busy_wb_alu", memWbAlu, 32'h0);
        checkOutput("rst_busy_wb_data", memWbData, 32'h0);
        checkOutput("rst_busy_wb_rd", wbRdAddr, 5'd0);
        checkOutput("rst_busy_wb_reg_write", wbRegWrite, 1'b0);
        @(negedge clk);
        rst_ = 1'b0;
        applyStimulus(1, 0, 0, F3W, 32'h12345678, 0, 5'd10, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_alu", memWbAlu, 32'h12345678);
        checkOutput("post_rst_rd", wbRdAddr, 5'd10);
        checkOutput("post_rst_reg_write", wbRegWrite, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
